// File: rtl/l2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : l2_pkg
// Description : Shared types and saturating add for the L2-norm datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package l2_pkg;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } l2_state_t;

    localparam int SAT_W = 64;

    // Returns {saturated, result}; result is clamped to 2^width-1 (width < SAT_W).
    function automatic logic [SAT_W:0] sat_add(
        input logic [SAT_W-1:0] a,
        input logic [SAT_W-1:0] b,
        input int               width
    );
        logic [SAT_W:0] sum;
        logic [SAT_W:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = ((SAT_W+1)'(1) << width) - (SAT_W+1)'(1);
        if (sum > lim) begin
            sat_add = {1'b1, lim[SAT_W-1:0]};
        end else begin
            sat_add = {1'b0, sum[SAT_W-1:0]};
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/l2_square.sv
`default_nettype none
// ============================================================================
// Module      : l2_square
// Description : Two-stage registered squarer (S1 element, S2 square) with
//               valid/last sideband.
// Revision    : 1.0 - initial release
// ============================================================================
module l2_square #(
    parameter int DATA_W = 8,
    parameter int SIGNED = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  in_last,
    output logic                  sq_valid,
    output logic [2*DATA_W-1:0]   sq_data,
    output logic                  sq_last
);

    logic                r_s1_valid;
    logic                r_s1_last;
    logic [DATA_W-1:0]   r_s1_data;
    logic                r_s2_valid;
    logic                r_s2_last;
    logic [2*DATA_W-1:0] r_s2_sq;
    logic [2*DATA_W-1:0] w_ext;
    logic [2*DATA_W-1:0] w_sq;

    // The true square always fits in 2*DATA_W bits, so a modular product of
    // the extended operand is exact for both signed and unsigned elements.
    generate
        if (SIGNED != 0) begin : g_signed_ext
            assign w_ext = {{DATA_W{r_s1_data[DATA_W-1]}}, r_s1_data};
        end else begin : g_unsigned_ext
            assign w_ext = {{DATA_W{1'b0}}, r_s1_data};
        end
    endgenerate

    assign w_sq = w_ext * w_ext;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else begin
            r_s1_valid <= in_valid;
            r_s2_valid <= r_s1_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid) begin
            r_s1_data <= in_data;
            r_s1_last <= in_last;
        end
        if (r_s1_valid) begin
            r_s2_sq   <= w_sq;
            r_s2_last <= r_s1_last;
        end
    end

    assign sq_valid = r_s2_valid;
    assign sq_data  = r_s2_sq;
    assign sq_last  = r_s2_last;

endmodule
`default_nettype wire

// File: rtl/l2_sumsq_stream.sv
`default_nettype none
// ============================================================================
// Module      : l2_sumsq_stream
// Description : Streaming sum-of-squares engine: squarer pipeline, saturating
//               S3 accumulator, element count and result hold handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module l2_sumsq_stream
    import l2_pkg::*;
#(
    parameter  int DATA_W  = 8,
    parameter  int SIGNED  = 0,
    parameter  int MAX_LEN = 16,
    localparam int CNT_W   = $clog2(MAX_LEN + 1),
    localparam int ACC_W   = 2 * DATA_W + CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_overflow
);

    l2_state_t             r_state;
    l2_state_t             w_state_next;
    logic                  w_accept;
    logic                  w_release;
    logic                  w_sq_valid;
    logic                  w_sq_last;
    logic [2*DATA_W-1:0]   w_sq_data;
    logic [SAT_W:0]        w_sat;
    logic                  w_unused_sat;
    logic [ACC_W-1:0]      r_acc;
    logic [CNT_W-1:0]      r_count;
    logic                  r_ovf;

    assign in_ready  = (r_state == ACCUM) && !reset;
    assign out_valid = (r_state == HOLD);
    assign w_accept  = in_valid && in_ready;
    assign w_release = out_valid && out_ready;

    l2_square #(
        .DATA_W (DATA_W),
        .SIGNED (SIGNED)
    ) u_square (
        .clk      (clk),
        .reset    (reset),
        .in_valid (w_accept),
        .in_data  (in_data),
        .in_last  (in_last),
        .sq_valid (w_sq_valid),
        .sq_data  (w_sq_data),
        .sq_last  (w_sq_last)
    );

    assign w_sat        = sat_add(SAT_W'(r_acc), SAT_W'(w_sq_data), ACC_W);
    assign w_unused_sat = ^w_sat[SAT_W-1:ACC_W];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_state_next;
        end
    end

    // DRAIN ends on the edge where the last square lands in the accumulator.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ACCUM:   if (w_accept && in_last)      w_state_next = DRAIN;
            DRAIN:   if (w_sq_valid && w_sq_last)  w_state_next = HOLD;
            HOLD:    if (out_ready)                w_state_next = ACCUM;
            default:                               w_state_next = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || w_release) begin
            r_acc   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_sq_valid) begin
                r_acc <= w_sat[ACC_W-1:0];
                if (w_sat[SAT_W]) begin
                    r_ovf <= 1'b1;
                end
            end
            if (w_accept) begin
                if (r_count == CNT_W'(MAX_LEN)) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_count <= r_count + CNT_W'(1);
                end
            end
        end
    end

    assign out_sum      = r_acc;
    assign out_count    = r_count;
    assign out_overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_l2_sumsq_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_l2_sumsq_stream
// Description : Directed table-driven bench; unsigned and signed instances
//               share one stimulus stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_l2_sumsq_stream;

    localparam int DW    = 8;
    localparam int ML    = 4;
    localparam int CW    = 3;
    localparam int AW    = 19;
    localparam int NVEC  = 7;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic          out_ready;

    logic          u_in_ready, u_out_valid, u_out_overflow;
    logic [AW-1:0] u_out_sum;
    logic [CW-1:0] u_out_count;
    logic          s_in_ready, s_out_valid, s_out_overflow;
    logic [AW-1:0] s_out_sum;
    logic [CW-1:0] s_out_count;

    int n_tests;
    int n_fail;

    typedef struct {
        int                 n;
        logic [9:0][DW-1:0] d;
        longint             sum_u;
        longint             sum_s;
        int                 cnt;
        int                 ovf;
    } vec_t;

    vec_t tbl [NVEC];

    l2_sumsq_stream #(.DATA_W(DW), .SIGNED(0), .MAX_LEN(ML)) u_dut_u (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(u_in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(u_out_valid),
        .out_ready(out_ready), .out_sum(u_out_sum), .out_count(u_out_count),
        .out_overflow(u_out_overflow)
    );

    l2_sumsq_stream #(.DATA_W(DW), .SIGNED(1), .MAX_LEN(ML)) u_dut_s (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(s_out_valid),
        .out_ready(out_ready), .out_sum(s_out_sum), .out_count(s_out_count),
        .out_overflow(s_out_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic fill(input int i, input int n, input logic [DW-1:0] v,
                        input longint su, input longint ss, input int c, input int o);
        tbl[i].n = n;
        for (int k = 0; k < 10; k++) tbl[i].d[k] = v;
        tbl[i].sum_u = su;
        tbl[i].sum_s = ss;
        tbl[i].cnt   = c;
        tbl[i].ovf   = o;
    endtask

    // Feed one vector, check latency, result on both instances, then accept it.
    task automatic run_vec(input string tag, input vec_t v);
        check({tag, ".in_ready"}, u_in_ready & s_in_ready, 1);
        for (int k = 0; k < v.n; k++) begin
            in_valid = 1'b1;
            in_data  = v.d[k];
            in_last  = (k == v.n - 1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check({tag, ".valid_e0"}, u_out_valid | s_out_valid, 0);
        @(negedge clk);
        check({tag, ".valid_e1"}, u_out_valid | s_out_valid, 0);
        check({tag, ".ready_drain"}, u_in_ready | s_in_ready, 0);
        @(negedge clk);
        check({tag, ".valid_e2"}, u_out_valid & s_out_valid, 1);
        check({tag, ".sum_u"}, u_out_sum, v.sum_u);
        check({tag, ".sum_s"}, s_out_sum, v.sum_s);
        check({tag, ".count_u"}, u_out_count, v.cnt);
        check({tag, ".count_s"}, s_out_count, v.cnt);
        check({tag, ".ovf_u"}, u_out_overflow, v.ovf);
        check({tag, ".ovf_s"}, s_out_overflow, v.ovf);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, ".released"}, u_out_valid | s_out_valid, 0);
        check({tag, ".ready_next"}, u_in_ready & s_in_ready, 1);
    endtask

    initial begin
        vec_t v;
        n_tests   = 0;
        n_fail    = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        fill(0, 2, 8'd4,   25,     25,    2, 0);
        tbl[0].d[0] = 8'd3;
        fill(1, 4, 8'hFF,  260100, 4,     4, 0);
        fill(2, 5, 8'hFF,  325125, 5,     4, 1);
        fill(3, 2, 8'h7F,  32513,  32513, 2, 0);
        tbl[3].d[0] = 8'h80;
        fill(4, 1, 8'hFF,  65025,  1,     1, 0);
        fill(5, 4, 8'h80,  65536,  65536, 4, 0);
        fill(6, 9, 8'hFF,  524287, 9,     4, 1);

        repeat (2) @(negedge clk);
        check("rst.in_ready", u_in_ready | s_in_ready, 0);
        check("rst.out_valid", u_out_valid | s_out_valid, 0);
        check("rst.sum", u_out_sum | s_out_sum, 0);
        check("rst.count", u_out_count | s_out_count, 0);
        check("rst.ovf", u_out_overflow | s_out_overflow, 0);
        reset = 1'b0;
        @(negedge clk);
        check("rst.ready_after", u_in_ready & s_in_ready, 1);

        for (int i = 0; i < NVEC; i++) begin
            run_vec($sformatf("vec%0d", i), tbl[i]);
        end

        // Backpressure: result held for 6 cycles, stray in_valid ignored.
        fill(0, 2, 8'd2, 5, 5, 2, 0);
        tbl[0].d[0] = 8'd1;
        in_valid = 1'b1; in_data = 8'd1; in_last = 1'b0;
        @(negedge clk);
        in_data = 8'd2; in_last = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        repeat (2) @(negedge clk);
        in_valid = 1'b1; in_data = 8'd9;
        for (int k = 0; k < 6; k++) begin
            check($sformatf("bp.valid%0d", k), u_out_valid & s_out_valid, 1);
            check($sformatf("bp.sum%0d", k), u_out_sum, 5);
            check($sformatf("bp.ready%0d", k), u_in_ready | s_in_ready, 0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("bp.sum_end", s_out_sum, 5);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp.released", u_out_valid, 0);
        fill(1, 1, 8'd2, 4, 4, 1, 0);
        run_vec("bp.next", tbl[1]);

        // Reset mid-vector discards the partial {7,7}.
        in_valid = 1'b1; in_data = 8'd7; in_last = 1'b0;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("mid.in_ready", u_in_ready | s_in_ready, 0);
        check("mid.sum", u_out_sum | s_out_sum, 0);
        check("mid.count", u_out_count, 0);
        reset = 1'b0;
        @(negedge clk);
        check("mid.ready_after", u_in_ready & s_in_ready, 1);
        repeat (3) @(negedge clk);
        check("mid.no_result", u_out_valid | s_out_valid, 0);
        fill(2, 1, 8'd1, 1, 1, 1, 0);
        v = tbl[2];
        run_vec("mid.next", v);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
